// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared seven-segment display constants and arbiter state encoding
package display_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam int DISP_DIGITS  = 8;
  localparam int DIGIT_W      = 4;
  localparam int DISP_VALUE_W = DISP_DIGITS * DIGIT_W;

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// rtl/display_arbiter_rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
  import display_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);

  int idx;

  // Scan from farthest to nearest so the nearest asserted index after last wins.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx[IW-1:0]]) begin
        valid = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the shared 8-digit display with hold time and blank gap
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MIN_HOLD     = 16777216,
  parameter int BLANK_CYCLES = 16384
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [DISP_VALUE_W*NUM_REQ-1:0] value_in,
  input  logic [DISP_DIGITS*NUM_REQ-1:0]  point_in,
  input  logic [DISP_DIGITS*NUM_REQ-1:0]  enable_in,
  output logic [NUM_REQ-1:0]              grant,
  output logic [DISP_VALUE_W-1:0]         value_out,
  output logic [DISP_DIGITS-1:0]          point_out,
  output logic [DISP_DIGITS-1:0]          enable_out,
  output logic                            busy
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int HOLD_W  = $clog2(MIN_HOLD + 1);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(MIN_HOLD - 1);
  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(BLANK_CYCLES - 1);

  logic [1:0]              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IW-1:0]           last_q, last_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [BLANK_W-1:0]      blank_cnt_q, blank_cnt_d;
  logic [DISP_VALUE_W-1:0] value_q, value_d;
  logic [DISP_DIGITS-1:0]  point_q, point_d;
  logic [DISP_DIGITS-1:0]  enable_q, enable_d;

  logic [IW-1:0]           pick_win;
  logic                    pick_valid;
  logic [IW-1:0]           sel;
  logic [DISP_VALUE_W-1:0] sel_value;
  logic [DISP_DIGITS-1:0]  sel_point;
  logic [DISP_DIGITS-1:0]  sel_enable;
  logic                    req_own;
  logic                    others;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // In IDLE the data source is the incoming winner; otherwise it is the current owner.
  assign sel     = (state_q == ST_IDLE) ? pick_win : last_q;
  assign req_own = req[last_q];
  assign others  = |(req & ~grant_q);

  always_comb begin
    sel_value  = '0;
    sel_point  = '0;
    sel_enable = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_value  = value_in[DISP_VALUE_W*i +: DISP_VALUE_W];
        sel_point  = point_in[DISP_DIGITS*i +: DISP_DIGITS];
        sel_enable = enable_in[DISP_DIGITS*i +: DISP_DIGITS];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    blank_cnt_d = blank_cnt_q;
    value_d     = value_q;
    point_d     = point_q;
    enable_d    = enable_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_win] = 1'b1;
          last_d            = pick_win;
          hold_cnt_d        = HOLD_INIT;
          state_d           = ST_SHOW;
          value_d           = sel_value;
          point_d           = sel_point;
          enable_d          = sel_enable;
        end else begin
          point_d  = '0;
          enable_d = '0;
        end
      end
      ST_SHOW: begin
        if (hold_cnt_q == '0 && (!req_own || others)) begin
          grant_d     = '0;
          point_d     = '0;
          enable_d    = '0;
          blank_cnt_d = BLANK_INIT;
          state_d     = ST_BLANK;
        end else begin
          if (req_own) begin
            value_d  = sel_value;
            point_d  = sel_point;
            enable_d = sel_enable;
          end
          if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == '0) state_d = ST_IDLE;
        else                   blank_cnt_d = blank_cnt_q - BLANK_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      hold_cnt_q  <= '0;
      blank_cnt_q <= '0;
      value_q     <= '0;
      point_q     <= '0;
      enable_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      value_q     <= value_d;
      point_q     <= point_d;
      enable_q    <= enable_d;
    end
  end

  assign grant      = grant_q;
  assign value_out  = value_q;
  assign point_out  = point_q;
  assign enable_out = enable_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed and random checks of display_arbiter against a tenure-level model
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int BC = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [32*N-1:0] value_in;
  logic [8*N-1:0]  point_in;
  logic [8*N-1:0]  enable_in;
  logic [N-1:0]    grant;
  logic [31:0]     value_out;
  logic [7:0]      point_out;
  logic [7:0]      enable_out;
  logic            busy;

  display_arbiter #(.NUM_REQ(N), .MIN_HOLD(MH), .BLANK_CYCLES(BC)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .value_in   (value_in),
    .point_in   (point_in),
    .enable_in  (enable_in),
    .grant      (grant),
    .value_out  (value_out),
    .point_out  (point_out),
    .enable_out (enable_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model: owner index (-1 none), cycles owned so far, blank cycles left before arbitration.
  int          m_owner, m_age, m_gap, m_last;
  logic [31:0] m_value;
  logic [7:0]  m_point, m_enable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_gap = 0; m_last = N - 1;
    m_value = '0; m_point = '0; m_enable = '0;
  endtask

  task automatic model_capture(input int c);
    m_value  = value_in[32*c +: 32];
    m_point  = point_in[8*c +: 8];
    m_enable = enable_in[8*c +: 8];
  endtask

  task automatic model_step();
    bit others;
    int c;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != m_owner && req[j]) others = 1'b1;
      if (m_age >= MH && (!req[m_owner] || others)) begin
        m_owner = -1; m_gap = BC; m_point = '0; m_enable = '0;
      end else begin
        if (req[m_owner]) model_capture(m_owner);
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N && m_owner < 0; k++) begin
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c; m_last = c; m_age = 1;
          model_capture(c);
        end
      end
      if (m_owner < 0) begin m_point = '0; m_enable = '0; end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk({tag, ".grant"},  32'(grant), 32'(eg));
    chk({tag, ".value"},  value_out, m_value);
    chk({tag, ".point"},  32'(point_out), 32'(m_point));
    chk({tag, ".enable"}, 32'(enable_out), 32'(m_enable));
    chk({tag, ".busy"},   32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
    chk({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) value_in[32*i +: 32] = $urandom();
    point_in  = $urandom();
    enable_in = $urandom();
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs(tag);
    #1 reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [N-1:0] target, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      if (grant === target) hit = 1'b1;
    end
    chk({tag, ".timeout"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      if (busy === 1'b0) hit = 1'b1;
    end
    chk({tag, ".timeout"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_next_grant(output logic [N-1:0] g, input int budget, input string tag);
    bit seen_zero, hit;
    seen_zero = (grant === '0);
    hit = 1'b0;
    g = '0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      if (grant === '0) seen_zero = 1'b1;
      else if (seen_zero) begin hit = 1'b1; g = grant; end
    end
    chk({tag, ".timeout"}, 32'(hit), 32'd1);
  endtask

  logic [N-1:0] order_q[$];
  logic [N-1:0] exp_order[5];
  logic [N-1:0] prev_g, g;
  int           hi_len, lo_len, tenures;
  logic [31:0]  frozen;

  initial begin
    reset = 1'b1; req = '0; value_in = '0; point_in = '0; enable_in = '0;
    model_reset();
    #8 check_outputs("por");
    #2 reset = 1'b0;

    // Full contention from reset: order 0,1,2,3,0 with 4-cycle tenures and 3-cycle gaps.
    req = '1;
    prev_g = '0; hi_len = 0; lo_len = 0; tenures = 0;
    for (int i = 0; i < 60 && order_q.size() < 5; i++) begin
      rand_data();
      cycle();
      if (grant !== '0) begin
        if (prev_g === '0) begin
          order_q.push_back(grant);
          if (tenures > 0) chk("gap_len", 32'(lo_len), BC + 1);
          tenures++;
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev_g !== '0) begin chk("tenure_len", 32'(hi_len), MH); lo_len = 0; end
        lo_len++;
        if (tenures > 0) chk("gap_enable", 32'(enable_out), 32'd0);
      end
      prev_g = grant;
    end
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    chk("order_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++) chk("order", 32'(order_q[i]), 32'(exp_order[i]));

    // Reset in the middle of requester 1's tenure.
    wait_grant(4'b0010, 30, "to_owner1");
    do_reset("rst_mid");
    chk("rst_mid.grant0", 32'(grant), 32'd0);
    chk("rst_mid.value0", value_out, 32'd0);
    chk("rst_mid.enable0", 32'(enable_out), 32'd0);
    cycle();
    chk("rst_first", 32'(grant), 32'b0001);

    // Single requester keeps the display indefinitely.
    @(posedge clock);
    do_reset("rst2");
    req = 4'b0100;
    rand_data();
    value_in[64 +: 32] = 32'h0000BEEF;
    enable_in[16 +: 8] = 8'h0F;
    cycle();
    chk("single.grant", 32'(grant), 32'b0100);
    chk("single.value", value_out, 32'h0000BEEF);
    chk("single.enable", 32'(enable_out), 32'h0F);
    repeat (12) cycle();
    chk("single.hold", 32'(grant), 32'b0100);
    chk("single.busy", 32'(busy), 32'd1);

    // Early release by owner 1 after one cycle of SHOW.
    req = '0;
    wait_idle(10, "idle1");
    req = 4'b0010;
    rand_data();
    cycle();
    chk("early.grant", 32'(grant), 32'b0010);
    frozen = value_in[32 +: 32];
    req = '0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
      chk("early.hold", 32'(grant), 32'b0010);
      chk("early.frozen", value_out, frozen);
    end
    cycle();
    chk("early.blank", 32'(grant), 32'd0);
    chk("early.blank_busy", 32'(busy), 32'd1);
    repeat (2) cycle();
    chk("early.idle", 32'(busy), 32'd0);

    // Live update by owner 3 while other slices churn.
    req = 4'b1000;
    rand_data();
    value_in[96 +: 32] = 32'h12345678;
    cycle();
    chk("live.grant", 32'(grant), 32'b1000);
    chk("live.first", value_out, 32'h12345678);
    rand_data();
    value_in[96 +: 32] = 32'hCAFEF00D;
    cycle();
    chk("live.update", value_out, 32'hCAFEF00D);
    value_in[95:0] = {$urandom(), $urandom(), $urandom()};
    cycle();
    chk("live.ignore", value_out, 32'hCAFEF00D);

    // Skip idle requesters: after owner 0, request 0 and 3 together -> 3 wins next.
    req = '0;
    wait_idle(12, "idle2");
    req = 4'b0001;
    cycle();
    chk("skip.own0", 32'(grant), 32'b0001);
    req = 4'b1001;
    wait_next_grant(g, 20, "skip");
    chk("skip.next", 32'(g), 32'b1000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      rand_data();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
